xbar_scheduler: RTL and testbench

//   Packet-level scheduler for the 3-source x 4-destination switch fabric.

---
 rtl/xbar_pkg.sv | 16 +
 rtl/rr_pick.sv | 29 ++
 rtl/xbar_scheduler.sv | 123 ++++++++++++
 tb/tb_xbar_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - sizes, index types and destination state for the crossbar scheduler
package xbar_pkg;
  localparam int N_SRC   = 3;
  localparam int N_DST   = 4;
  localparam int DST_W   = $clog2(N_DST);
  localparam int SRC_W   = $clog2(N_SRC);
  localparam int AGE_MAX = 7;

  typedef logic [SRC_W-1:0] src_idx_t;
  typedef logic [DST_W-1:0] dst_idx_t;
  typedef enum logic {DST_IDLE, DST_LOCKED} dst_state_t;

  function automatic dst_idx_t dst_of(input logic [N_SRC*DST_W-1:0] req_dst, input int s);
    return req_dst[s*DST_W +: DST_W];
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: first candidate at or after ptr, aged candidates first
module rr_pick
  import xbar_pkg::*;
(
  input  logic [N_SRC-1:0] cand,
  input  logic [N_SRC-1:0] aged,
  input  src_idx_t         ptr,
  output src_idx_t         win,
  output logic             any
);
  logic [N_SRC-1:0] pool;

  always_comb begin
    int       idx;
    src_idx_t k;
    pool = (|(cand & aged)) ? (cand & aged) : cand;
    win  = '0;
    idx  = 0;
    k    = '0;
    // Scan backwards so the last hit written is the first in rotated order.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_SRC) idx -= N_SRC;
      k = src_idx_t'(idx);
      if (pool[k]) win = k;
    end
    any = |cand;
  end
endmodule

// File: rtl/xbar_scheduler.sv
// rtl/xbar_scheduler.sv - 3x4 fabric packet scheduler, per-destination round-robin port lock
// AGE_LIMIT_EN: sources starved for AGE_MAX cycles win arbitration ahead of round-robin order.
module xbar_scheduler
  import xbar_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         req_valid,
  input  logic [N_SRC*DST_W-1:0]   req_dst,
  input  logic [N_SRC-1:0]         req_last,
  output logic [N_SRC-1:0]         req_ready,
  output logic [N_DST*SRC_W-1:0]   sel,
  output logic [N_DST-1:0]         sel_valid,
  output logic [N_SRC-1:0]         fail,
  output logic                     busy
);
  dst_state_t       state [N_DST];
  dst_state_t       state_nxt [N_DST];
  src_idx_t         owner [N_DST];
  src_idx_t         owner_nxt [N_DST];
  src_idx_t         ptr [N_DST];
  src_idx_t         ptr_nxt [N_DST];
  logic [N_SRC-1:0] cand [N_DST];
  src_idx_t         win [N_DST];
  logic [N_DST-1:0] has_cand;
  logic [N_SRC-1:0] aged, owns, granted, held, fail_nxt;

  // A source holding any port is kept out of every other arbitration.
  always_comb begin
    owns = '0;
    for (int d = 0; d < N_DST; d++)
      if (state[d] == DST_LOCKED) owns[owner[d]] = 1'b1;
    for (int d = 0; d < N_DST; d++)
      for (int s = 0; s < N_SRC; s++)
        cand[d][s] = (state[d] == DST_IDLE) && req_valid[s] && !owns[s] &&
                     (dst_of(req_dst, s) == dst_idx_t'(d));
  end

  for (genvar d = 0; d < N_DST; d++) begin : g_pick
    rr_pick u_pick (
      .cand (cand[d]),
      .aged (aged),
      .ptr  (ptr[d]),
      .win  (win[d]),
      .any  (has_cand[d])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < N_DST; d++) begin
        state[d] <= DST_IDLE;
        owner[d] <= '0;
        ptr[d]   <= '0;
      end
      fail <= '0;
    end else begin
      for (int d = 0; d < N_DST; d++) begin
        state[d] <= state_nxt[d];
        owner[d] <= owner_nxt[d];
        ptr[d]   <= ptr_nxt[d];
      end
      fail <= fail_nxt;
    end
  end

  always_comb begin
    granted = '0;
    held    = '0;
    for (int d = 0; d < N_DST; d++) begin
      state_nxt[d] = state[d];
      owner_nxt[d] = owner[d];
      ptr_nxt[d]   = ptr[d];
      if (state[d] == DST_IDLE) begin
        if (has_cand[d]) begin
          state_nxt[d] = DST_LOCKED;
          owner_nxt[d] = win[d];
          ptr_nxt[d]   = (win[d] == src_idx_t'(N_SRC - 1)) ? '0 : win[d] + 1'b1;
          granted[win[d]] = 1'b1;
        end
      end else if (req_valid[owner[d]] && dst_of(req_dst, int'(owner[d])) == dst_idx_t'(d)) begin
        held[owner[d]] = 1'b1;
        if (req_last[owner[d]]) state_nxt[d] = DST_IDLE;
      end
    end
    fail_nxt = req_valid & ~(granted | held);
  end

  always_comb begin
    req_ready = '0;
    sel       = '0;
    sel_valid = '0;
    for (int d = 0; d < N_DST; d++) begin
      sel[d*SRC_W +: SRC_W] = owner[d];
      sel_valid[d] = (state[d] == DST_LOCKED);
      if (sel_valid[d] && req_valid[owner[d]] &&
          dst_of(req_dst, int'(owner[d])) == dst_idx_t'(d))
        req_ready[owner[d]] = 1'b1;
    end
    busy = |sel_valid;
  end

`ifdef AGE_LIMIT_EN
  logic [2:0] age [N_SRC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_SRC; s++) age[s] <= '0;
    end else begin
      for (int s = 0; s < N_SRC; s++)
        if (granted[s]) age[s] <= '0;
        else if (fail_nxt[s] && age[s] != 3'b111) age[s] <= age[s] + 3'd1;
    end
  end

  always_comb begin
    aged = '0;
    for (int s = 0; s < N_SRC; s++) aged[s] = (age[s] >= 3'(AGE_MAX));
  end
`else
  assign aged = '0;
`endif
endmodule

// File: tb/tb_xbar_scheduler.sv
// tb/tb_xbar_scheduler.sv - scoreboard bench for xbar_scheduler; AGE_LIMIT_EN selects the aged-winner expectation
module tb_xbar_scheduler;
  import xbar_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_SRC-1:0]       req_valid = '0;
  logic [N_SRC-1:0]       req_last = '0;
  logic [N_SRC*DST_W-1:0] req_dst = '0;
  logic [N_SRC-1:0]       req_ready, fail;
  logic [N_DST*SRC_W-1:0] sel;
  logic [N_DST-1:0]       sel_valid;
  logic                   busy;

  xbar_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dst(req_dst), .req_last(req_last),
    .req_ready(req_ready), .sel(sel), .sel_valid(sel_valid), .fail(fail), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int start; int dst; int beats; } pkt_t;
  typedef struct { int cyc; int src; int dst; int last; } xfer_t;
  typedef struct { int cyc; string name; int sv; int fl; int sel_d; int sel_s; bit all_zero; } snap_t;

  pkt_t             pkt_q [N_SRC][$];
  xfer_t            xfer_q[$];
  snap_t            snap_q[$];
  int               cyc = 0;
  logic [N_SRC-1:0] acc = '0;
  bit               done = 1'b0;
  int               n_chk = 0;
  int               n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic pkt(input int s, input int d, input int beats, input int start);
    pkt_t p;
    p.start = start; p.dst = d; p.beats = beats;
    pkt_q[s].push_back(p);
  endtask

  task automatic xf(input int c, input int s, input int d, input int last);
    xfer_t x;
    x.cyc = c; x.src = s; x.dst = d; x.last = last;
    xfer_q.push_back(x);
  endtask

  task automatic sn(input int c, input string name, input int sv, input int fl,
                    input int sel_d, input int sel_s, input bit all_zero);
    snap_t p;
    p.cyc = c; p.name = name; p.sv = sv; p.fl = fl;
    p.sel_d = sel_d; p.sel_s = sel_s; p.all_zero = all_zero;
    snap_q.push_back(p);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Well-behaved valid/ready sources: hold each beat until accepted, drop everything on reset.
  initial begin : driver
    bit act [N_SRC];
    int left [N_SRC];
    int dst [N_SRC];
    for (int s = 0; s < N_SRC; s++) begin
      act[s] = 1'b0; left[s] = 0; dst[s] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < N_SRC; s++) begin
        if (rst) begin
          act[s] = 1'b0;
          pkt_q[s].delete();
        end else begin
          if (act[s] && acc[s]) begin
            left[s]--;
            if (left[s] == 0) act[s] = 1'b0;
          end
          if (!act[s] && pkt_q[s].size() > 0 && pkt_q[s][0].start <= cyc) begin
            act[s]  = 1'b1;
            left[s] = pkt_q[s][0].beats;
            dst[s]  = pkt_q[s][0].dst;
            void'(pkt_q[s].pop_front());
          end
        end
        req_valid[s] = act[s];
        req_last[s]  = act[s] && (left[s] == 1);
        req_dst[s*DST_W +: DST_W] = dst[s][DST_W-1:0];
      end
    end
  end

  initial begin : monitor
    xfer_t x;
    snap_t p;
    int    so;
    while (!done) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (!rst) begin
        for (int s = 0; s < N_SRC; s++) begin
          if (acc[s]) begin
            if (xfer_q.size() == 0) begin
              chk($sformatf("unexpected_xfer_src%0d", s), 1, 0);
            end else begin
              x = xfer_q.pop_front();
              chk("xfer(cyc*1000+src*100+dst*10+last)",
                  cyc*1000 + s*100 + int'(req_dst[s*DST_W +: DST_W])*10 + int'(req_last[s]),
                  x.cyc*1000 + x.src*100 + x.dst*10 + x.last);
            end
          end
        end
      end
      for (int d = 0; d < N_DST; d++) begin
        so = int'(sel[d*SRC_W +: SRC_W]);
        if (sel_valid[d] && so < N_SRC && req_valid[so])
          chk($sformatf("owner_dst_stable_d%0d", d), req_dst[so*DST_W +: DST_W], d);
      end
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
        p = snap_q.pop_front();
        if (p.cyc < cyc) begin
          chk({p.name, ".missed"}, 0, 1);
        end else begin
          chk({p.name, ".sel_valid"}, sel_valid, p.sv);
          chk({p.name, ".fail"}, fail, p.fl);
          chk({p.name, ".busy"}, busy, p.sv != 0);
          if (p.sel_d >= 0) chk({p.name, ".sel"}, sel[p.sel_d*SRC_W +: SRC_W], p.sel_s);
          if (p.all_zero) begin
            chk({p.name, ".sel_all"}, sel, 0);
            chk({p.name, ".req_ready"}, req_ready, 0);
          end
        end
      end
    end
    chk("xfer_leftover", xfer_q.size(), 0);
    chk("snap_leftover", snap_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : stim
    int b;
    int w;
    int other;
    sn(2, "reset", 0, 0, -1, 0, 1);
    goto(3);
    #1 rst = 1'b0;

    // single-beat z -> dst 1
    b = 5; goto(b - 1);
    pkt(0, 1, 1, b);
    xf(b + 1, 0, 1, 1);
    sn(b + 1, "t1_lock", 4'b0010, 3'b000, 1, 0, 0);
    sn(b + 2, "t1_free", 4'b0000, 3'b000, -1, 0, 0);

    // x, y, z contend for dst 2 with 2-beat packets: z, y, x with one-cycle bubbles
    b = 9; goto(b - 1);
    pkt(2, 2, 2, b); pkt(1, 2, 2, b); pkt(0, 2, 2, b);
    xf(b + 1, 0, 2, 0); xf(b + 2, 0, 2, 1);
    xf(b + 4, 1, 2, 0); xf(b + 5, 1, 2, 1);
    xf(b + 7, 2, 2, 0); xf(b + 8, 2, 2, 1);
    sn(b + 1, "t2_z", 4'b0100, 3'b110, 2, 0, 0);
    sn(b + 3, "t2_bubble1", 4'b0000, 3'b110, -1, 0, 0);
    sn(b + 4, "t2_y", 4'b0100, 3'b100, 2, 1, 0);
    sn(b + 6, "t2_bubble2", 4'b0000, 3'b100, -1, 0, 0);
    sn(b + 7, "t2_x", 4'b0100, 3'b000, 2, 2, 0);
    sn(b + 9, "t2_done", 4'b0000, 3'b000, -1, 0, 0);

    // independent destinations in parallel
    b = 20; goto(b - 1);
    pkt(2, 0, 1, b); pkt(1, 1, 1, b); pkt(0, 3, 1, b);
    xf(b + 1, 0, 3, 1); xf(b + 1, 1, 1, 1); xf(b + 1, 2, 0, 1);
    sn(b + 1, "t3_parallel", 4'b1011, 3'b000, 0, 2, 0);
    sn(b + 2, "t3_free", 4'b0000, 3'b000, -1, 0, 0);

    // y takes dst 3 so ptr[3] = 2, then x and z: x wins, ptr wraps, z next
    b = 24; goto(b - 1);
    pkt(1, 3, 1, b);
    xf(b + 1, 1, 3, 1);
    b = 27; goto(b - 1);
    pkt(2, 3, 1, b); pkt(0, 3, 1, b);
    xf(b + 1, 2, 3, 1); xf(b + 3, 0, 3, 1);
    sn(b + 1, "t5_x", 4'b1000, 3'b001, 3, 2, 0);
    sn(b + 2, "t5_bubble", 4'b0000, 3'b001, -1, 0, 0);
    sn(b + 3, "t5_z", 4'b1000, 3'b000, 3, 0, 0);

    // reset at beat 2 of a 4-beat x -> dst 2 packet
    b = 32; goto(b - 1);
    pkt(2, 2, 4, b);
    xf(b + 1, 2, 2, 0);
    sn(b + 2, "t4_in_reset", 4'b0000, 3'b000, -1, 0, 1);
    sn(b + 3, "t4_reset_hold", 4'b0000, 3'b000, -1, 0, 1);
    goto(b + 2);
    #1 rst = 1'b1;
    goto(b + 4);
    #1 rst = 1'b0;
    pkt(1, 2, 1, b + 5); pkt(0, 2, 1, b + 5);
    xf(b + 6, 0, 2, 1); xf(b + 8, 1, 2, 1);
    sn(b + 6, "t4_after", 4'b0100, 3'b010, 2, 0, 0);

    // y starves behind a 12-beat x packet on dst 0; z arrives late
    b = 42; goto(b - 1);
`ifdef AGE_LIMIT_EN
    w = 1; other = 0;
`else
    w = 0; other = 1;
`endif
    pkt(2, 0, 12, b); pkt(1, 0, 1, b + 1); pkt(0, 0, 1, b + 9);
    for (int i = 0; i < 12; i++) xf(b + 1 + i, 2, 0, (i == 11) ? 1 : 0);
    xf(b + 14, w, 0, 1); xf(b + 16, other, 0, 1);
    sn(b + 5, "t6_hold", 4'b0001, 3'b010, 0, 2, 0);
    sn(b + 10, "t6_both_wait", 4'b0001, 3'b011, 0, 2, 0);
    sn(b + 14, "t6_release", 4'b0001, 1 << other, 0, w, 0);
    goto(b + 20);
    done = 1'b1;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 100", cyc);
    $fatal(1);
  end
endmodule
